// File: rtl/operand_dispatch.sv
// -----------------------------------------------------------------------------
// operand_dispatch
//   Routes one issued operation (opcode + two operands) through a single
//   registered holding stage to one of four execution channels:
//     ch0 arith   (opcode 00000..00001)
//     ch1 bitwise (opcode 00010..00011)
//     ch2 shift   (opcode 00100..00101)
//     ch3 other   (opcode 00110..11111)
//   Handshake is valid/ready on both sides. Full throughput of 1 op/clk is
//   kept because a consume and a new accept may happen in the same cycle.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   flush        synchronous clear of the holding stage, highest priority
//   in_valid     upstream offers an operation
//   in_ready     operation accepted this cycle when in_valid & in_ready
//   in_opcode    5-bit ALU opcode
//   in_a, in_b   operands
//   out_valid    one-hot target channel of the held operation
//   out_ready    per-channel consume strobe (only the selected bit matters)
//   out_opcode   held opcode (shared by all channels)
//   out_a, out_b held operands (shared by all channels)
//   cnt_ch0..3   wrapping count of operations consumed per channel
// -----------------------------------------------------------------------------
module operand_dispatch #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       in_opcode,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [4:0]       out_opcode,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic [CNT_W-1:0] cnt_ch0,
    output logic [CNT_W-1:0] cnt_ch1,
    output logic [CNT_W-1:0] cnt_ch2,
    output logic [CNT_W-1:0] cnt_ch3
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    // Opcode to one-hot channel; everything above 00101 lands on ch3.
    function automatic logic [3:0] route(input logic [4:0] opcode);
        logic [3:0] onehot;
        if (opcode < 5'd2)      onehot = 4'b0001;
        else if (opcode < 5'd4) onehot = 4'b0010;
        else if (opcode < 5'd6) onehot = 4'b0100;
        else                    onehot = 4'b1000;
        return onehot;
    endfunction

    state_t             state_q, state_d;
    logic               rdy_en_q;
    logic [3:0]         sel_p1;
    logic [4:0]         opcode_p1;
    logic [WIDTH-1:0]   a_p1;
    logic [WIDTH-1:0]   b_p1;
    logic [CNT_W-1:0]   cnt_p1 [4];

    logic               vld_p1;
    logic               consume;
    logic               accept;
    logic               load;
    logic               clr;

    assign vld_p1   = (state_q == FULL);
    // Only the selected channel's ready bit can consume; sel_p1 is zero when EMPTY.
    assign consume  = !flush && vld_p1 && ((sel_p1 & out_ready) != 4'b0000);
    // rdy_en_q keeps in_ready low until the first edge after reset release.
    assign in_ready = rdy_en_q && !flush && (!vld_p1 || ((sel_p1 & out_ready) != 4'b0000));
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        clr     = 1'b0;
        if (flush) begin
            state_d = EMPTY;
            clr     = 1'b1;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d = FULL;
                        load    = 1'b1;
                    end
                end
                FULL: begin
                    if (accept) begin
                        load = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                        clr     = 1'b1;
                    end
                end
                default: begin
                    state_d = EMPTY;
                    clr     = 1'b1;
                end
            endcase
        end
    end

    // ---- holding stage (p1) ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            rdy_en_q  <= 1'b0;
            sel_p1    <= 4'b0000;
            opcode_p1 <= 5'd0;
            a_p1      <= '0;
            b_p1      <= '0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
            if (load) begin
                sel_p1    <= route(in_opcode);
                opcode_p1 <= in_opcode;
                a_p1      <= in_a;
                b_p1      <= in_b;
            end else if (clr) begin
                // Data is left as-is on clear; only the channel select drops.
                sel_p1 <= 4'b0000;
            end
        end
    end

    // ---- per-channel consume counters ----
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int c = 0; c < 4; c++) cnt_p1[c] <= '0;
        end else begin
            for (int c = 0; c < 4; c++) begin
                if (consume && sel_p1[c]) cnt_p1[c] <= cnt_p1[c] + CNT_W'(1);
            end
        end
    end

    assign out_valid  = sel_p1;
    assign out_opcode = opcode_p1;
    assign out_a      = a_p1;
    assign out_b      = b_p1;
    assign cnt_ch0    = cnt_p1[0];
    assign cnt_ch1    = cnt_p1[1];
    assign cnt_ch2    = cnt_p1[2];
    assign cnt_ch3    = cnt_p1[3];

endmodule

// File: tb/tb_operand_dispatch.sv
// -----------------------------------------------------------------------------
// tb_operand_dispatch
//   Directed bench for operand_dispatch: reset (including mid-run async reset),
//   routing, back-pressure, streaming, flush and counter wrap. Inputs change
//   1 time unit after the rising edge; outputs are checked there too.
// -----------------------------------------------------------------------------
module tb_operand_dispatch;

    localparam int WIDTH = 32;
    localparam int CNT_W = 8;

    logic             clock;
    logic             reset_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       in_opcode;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [4:0]       out_opcode;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic [CNT_W-1:0] cnt_ch0, cnt_ch1, cnt_ch2, cnt_ch3;

    int n_checks = 0;
    int n_errors = 0;

    operand_dispatch #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_opcode  (in_opcode),
        .in_a       (in_a),
        .in_b       (in_b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_opcode (out_opcode),
        .out_a      (out_a),
        .out_b      (out_b),
        .cnt_ch0    (cnt_ch0),
        .cnt_ch1    (cnt_ch1),
        .cnt_ch2    (cnt_ch2),
        .cnt_ch3    (cnt_ch3)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        #2;
        reset_n = 1'b1;
        step();
    endtask

    // Channel one-hot invariant, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset_n) chk("onehot0", 64'($onehot0(out_valid)), 64'd1);
    end

    logic [4:0] route_ops [5];
    logic [3:0] route_exp [5];

    initial begin
        route_ops[0] = 5'b00000; route_exp[0] = 4'b0001;
        route_ops[1] = 5'b00011; route_exp[1] = 4'b0010;
        route_ops[2] = 5'b00101; route_exp[2] = 4'b0100;
        route_ops[3] = 5'b00110; route_exp[3] = 4'b1000;
        route_ops[4] = 5'b11111; route_exp[4] = 4'b1000;

        reset_n   = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_opcode = 5'd0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 4'b0000;
        #12;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_out_a", 64'(out_a), 64'd0);
        chk("rst_cnt0", 64'(cnt_ch0), 64'd0);
        #1 reset_n = 1'b1;
        #1;
        chk("rel_in_ready_pre_edge", 64'(in_ready), 64'd0);
        step();
        chk("rel_in_ready_post_edge", 64'(in_ready), 64'd1);

        // ---------------- routing ----------------
        out_ready = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_opcode = route_ops[i];
            in_a      = 32'h1000 + i;
            in_b      = 32'h2000 + i;
            step();
            chk($sformatf("route_valid_%0d", i), 64'(out_valid), 64'(route_exp[i]));
            chk($sformatf("route_a_%0d", i), 64'(out_a), 64'(32'h1000 + i));
            chk($sformatf("route_op_%0d", i), 64'(out_opcode), 64'(route_ops[i]));
        end
        in_valid = 1'b0;
        step();
        chk("route_cnt0", 64'(cnt_ch0), 64'd1);
        chk("route_cnt1", 64'(cnt_ch1), 64'd1);
        chk("route_cnt2", 64'(cnt_ch2), 64'd1);
        chk("route_cnt3", 64'(cnt_ch3), 64'd2);
        chk("route_empty", 64'(out_valid), 64'd0);

        // ---------------- mid-run async reset ----------------
        out_ready = 4'b0000;
        in_valid  = 1'b1;
        in_opcode = 5'b00100;
        step();
        in_valid = 1'b0;
        chk("mrst_full", 64'(out_valid), 64'b0100);
        #2 reset_n = 1'b0;
        #1;
        chk("mrst_out_valid", 64'(out_valid), 64'd0);
        chk("mrst_cnt0", 64'(cnt_ch0), 64'd0);
        chk("mrst_cnt3", 64'(cnt_ch3), 64'd0);
        chk("mrst_in_ready", 64'(in_ready), 64'd0);
        step();
        #2 reset_n = 1'b1;
        #1;
        chk("mrst_rel_pre_edge", 64'(in_ready), 64'd0);
        step();
        chk("mrst_rel_post_edge", 64'(in_ready), 64'd1);

        // ---------------- back-pressure ----------------
        do_reset();
        in_valid  = 1'b1;
        in_opcode = 5'b00010;
        in_a      = 32'hDEADBEEF;
        in_b      = 32'h0BADF00D;
        step();
        in_opcode = 5'b00000;
        in_a      = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", 64'(in_ready), 64'd0);
            step();
            chk("bp_valid", 64'(out_valid), 64'b0010);
            chk("bp_a", 64'(out_a), 64'hDEADBEEF);
        end
        out_ready = 4'b0001;
        #1;
        chk("bp_wrong_ready", 64'(in_ready), 64'd0);
        step();
        chk("bp_wrong_valid", 64'(out_valid), 64'b0010);
        chk("bp_wrong_cnt0", 64'(cnt_ch0), 64'd0);
        chk("bp_wrong_cnt1", 64'(cnt_ch1), 64'd0);
        in_valid  = 1'b0;
        out_ready = 4'b0010;
        #1;
        chk("bp_ready_up", 64'(in_ready), 64'd1);
        step();
        chk("bp_cnt1", 64'(cnt_ch1), 64'd1);
        chk("bp_empty", 64'(out_valid), 64'd0);

        // ---------------- streaming ----------------
        do_reset();
        out_ready = 4'b1111;
        for (int i = 0; i < 16; i++) begin
            in_valid  = 1'b1;
            in_opcode = (i % 2 == 0) ? 5'b00000 : 5'b00100;
            in_a      = 32'hA000 + i;
            #1;
            chk($sformatf("stream_ready_%0d", i), 64'(in_ready), 64'd1);
            step();
            chk($sformatf("stream_valid_%0d", i), 64'(out_valid),
                (i % 2 == 0) ? 64'b0001 : 64'b0100);
            chk($sformatf("stream_a_%0d", i), 64'(out_a), 64'(32'hA000 + i));
        end
        in_valid = 1'b0;
        step();
        chk("stream_cnt0", 64'(cnt_ch0), 64'd8);
        chk("stream_cnt2", 64'(cnt_ch2), 64'd8);
        chk("stream_cnt1", 64'(cnt_ch1), 64'd0);

        // ---------------- flush ----------------
        do_reset();
        in_valid  = 1'b1;
        in_opcode = 5'b00111;
        step();
        out_ready = 4'b1000;
        in_opcode = 5'b00110;
        step();
        chk("fl_pre_cnt3", 64'(cnt_ch3), 64'd1);
        chk("fl_pre_valid", 64'(out_valid), 64'b1000);
        flush     = 1'b1;
        in_opcode = 5'b00000;
        #1;
        chk("fl_in_ready", 64'(in_ready), 64'd0);
        step();
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 4'b0000;
        chk("fl_valid", 64'(out_valid), 64'd0);
        chk("fl_cnt3", 64'(cnt_ch3), 64'd1);
        chk("fl_cnt0", 64'(cnt_ch0), 64'd0);
        step();
        chk("fl_not_taken", 64'(out_valid), 64'd0);

        // ---------------- counter wrap ----------------
        do_reset();
        out_ready = 4'b0010;
        in_valid  = 1'b1;
        in_opcode = 5'b00011;
        for (int i = 0; i < 256; i++) step();
        chk("wrap_255", 64'(cnt_ch1), 64'd255);
        in_valid = 1'b0;
        step();
        chk("wrap_256", 64'(cnt_ch1), 64'd0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        chk("wrap_257", 64'(cnt_ch1), 64'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
